muldiv_unit: RTL and testbench

- Multi-cycle MIPS integer multiply/divide unit with architectural HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI/MFLO read path).
- Sits in the execute stage beside the single-cycle ALU (EU).
- Consumes the decode stage's rs/rt operands (data1/data2) and an op strobe.
- Exposes HI/LO to the execute/writeback path, and `busy` so decode stalls MFHI/MFLO and further mul/div ops.

---
 rtl/muldiv_unit_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// ---- muldiv_unit_pkg : shared encodings, state type and helpers (rev 1.0) ----
`default_nettype none

package muldiv_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ---- muldiv_step : one radix-2 shift-add / restoring-divide iteration (rev 1.0) ----
`default_nettype none

module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // acc holds {product_hi, multiplier} for multiply, {remainder, quotient} for divide
  always_comb begin
    sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    shifted = acc_in[2*XLEN-1:XLEN-1];
    diff    = shifted - {1'b0, opnd};
    if (is_div) begin
      if (!diff[XLEN]) begin
        acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
      end else begin
        acc_out = {shifted[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_out = {sum, acc_in[XLEN-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ---- muldiv_unit : multi-cycle MIPS MULT/MULTU/DIV/DIVU with HI/LO registers (rev 1.0) ----
`default_nettype none

module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic            flush,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out,
  output logic            busy,
  output logic            done
);

  import muldiv_unit_pkg::*;

  localparam int CW = $clog2(ITERS);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;
  logic                neg_rem_q, neg_rem_d;
  logic                div0_q, div0_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic                done_q, done_d;

  logic [2*XLEN-1:0]   step_out;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix;
  logic [XLEN-1:0]     rem_fix;
  logic                is_signed;
  logic                last_iter;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_div_q),
    .acc_in  (acc_q),
    .opnd    (opnd_q),
    .acc_out (step_out)
  );

  assign last_iter = (cnt_q == CW'(ITERS - 1));

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !flush) state_d = RUN;
      RUN:     if (flush) state_d = IDLE;
               else if (last_iter) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    done   = done_q;
    hi_out = hi_q;
    lo_out = lo_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = (state_q == FIX) && !flush;
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix   = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

    case (state_q)
      IDLE: begin
        if (mthi) hi_d = data1;
        if (mtlo) lo_d = data1;
        if (start && !flush) begin
          cnt_d    = '0;
          is_div_d = op[1];
          div0_d   = op[1] && (data2 == '0);
          // Divide-by-zero runs unsigned on the raw dividend so the remainder lands as data1
          if (op[1] && (data2 == '0)) begin
            acc_d     = {{XLEN{1'b0}}, data1};
            opnd_d    = '0;
            neg_d     = 1'b0;
            neg_rem_d = 1'b0;
          end else begin
            acc_d     = {{XLEN{1'b0}}, (is_signed ? abs_val(data1) : data1)};
            opnd_d    = is_signed ? abs_val(data2) : data2;
            neg_d     = is_signed && (data1[XLEN-1] ^ data2[XLEN-1]);
            neg_rem_d = is_signed && op[1] && data1[XLEN-1];
          end
        end
      end
      RUN: begin
        if (!flush) begin
          acc_d = step_out;
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        if (!flush) begin
          if (!is_div_q) begin
            hi_d = prod_fix[2*XLEN-1:XLEN];
            lo_d = prod_fix[XLEN-1:0];
          end else if (div0_q) begin
            hi_d = acc_q[2*XLEN-1:XLEN];
            lo_d = DIV0_QUOT;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ---- tb_muldiv_unit : directed vector bench for muldiv_unit (rev 1.0) ----
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] hi_out, lo_out;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .data1  (data1),
    .data2  (data2),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .flush  (flush),
    .hi_out (hi_out),
    .lo_out (lo_out),
    .busy   (busy),
    .done   (done)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Launch one op; lat = edges after the accepting edge until done, busy_cnt = sampled busy cycles
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    op = o; data1 = a; data2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) lat = k;
    end
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done) lat = k;
    end
  endtask

  initial begin
    int lat, bc, dcount;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[6] = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[7] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8] = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[9] = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", hi_out, 32'h0);
    check("reset_lo", lo_out, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    @(negedge clk); reset = 1'b1;

    // Table-driven results, latency and busy length
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
      check($sformatf("v%0d_latency", i), lat, 32'd33);
      check($sformatf("v%0d_busy_cycles", i), bc, 32'd33);
      check($sformatf("v%0d_hi", i), hi_out, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo_out, vecs[i].lo);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_one_cycle", i), {31'b0, done}, 32'h0);
    end

    // MTHI in IDLE, then start/mtlo while busy are ignored
    @(negedge clk); data1 = 32'h1234; mthi = 1'b1;
    @(posedge clk); #1; mthi = 1'b0;
    check("mthi_idle", hi_out, 32'h1234);
    @(negedge clk); op = 2'b01; data1 = 32'd5; data2 = 32'd6; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); op = 2'b00; data1 = 32'd2; data2 = 32'd2; start = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1; start = 1'b0; mtlo = 1'b0;
    check("busy_mtlo_ignored", lo_out, 32'h1234_5678 & 32'h0 | vecs[9].lo);
    wait_done(lat);
    check("ignored_start_latency", lat, 32'd30);
    check("ignored_start_hi", hi_out, 32'd0);
    check("ignored_start_lo", lo_out, 32'd30);

    // Flush mid-run keeps HI/LO and never pulses done
    @(negedge clk); data1 = 32'hABCD; mthi = 1'b1;
    @(posedge clk); #1; mthi = 1'b0;
    @(negedge clk); op = 2'b01; data1 = 32'd9; data2 = 32'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'h0);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("flush_no_done", dcount, 32'd0);
    check("flush_hi", hi_out, 32'hABCD);
    check("flush_lo", lo_out, 32'd30);

    // Flush beats start in IDLE
    @(negedge clk); op = 2'b01; data1 = 32'd3; data2 = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    check("flush_blocks_start", {31'b0, busy}, 32'h0);

    // Reset mid-divide discards everything
    @(negedge clk); op = 2'b11; data1 = 32'd1000; data2 = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("midreset_busy", {31'b0, busy}, 32'h0);
    check("midreset_done", {31'b0, done}, 32'h0);
    check("midreset_hi", hi_out, 32'h0);
    check("midreset_lo", lo_out, 32'h0);
    @(negedge clk); reset = 1'b1;
    run_op(2'b11, 32'd1000, 32'd7, lat, bc);
    check("post_reset_latency", lat, 32'd33);
    check("post_reset_hi", hi_out, 32'd6);
    check("post_reset_lo", lo_out, 32'd142);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
